ascon_init_loader: RTL and testbench

//  Upstream feeder for the Ascon permutation FSM (Ascon-128 initialization phase).
//  - Collects key and nonce as eight 32-bit words over a valid/ready stream.
//  - Builds the 320-bit state IV||K||N and launches one permutation run.
//  - XORs 0^192||K into the permuted state and presents it, with K, to the downstream AD/PT stage.

---
 rtl/ascon_init_loader.sv | 108 ++++++++++
 tb/tb_ascon_init_loader.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_init_loader.sv
// Ascon-128 initialization loader: collects K||N from a 32-bit stream, launches one
// permutation on {IV,K,N}, folds K into the permuted state and hands it downstream.
module ascon_init_loader #(
  parameter logic [63:0] IV = 64'h80400C0600000000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  output logic         perm_start,
  output logic [319:0] perm_state,
  input  logic         perm_done,
  input  logic [319:0] perm_out,
  output logic         st_valid,
  input  logic         st_ready,
  output logic [319:0] st_out,
  output logic [127:0] key_out
);

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, XOR, HOLD} state_t;

  state_t         state_q, state_d;
  logic [2:0]     cnt_q, cnt_d;
  logic [255:0]   kn_q, kn_d;
  logic [127:0]   key_q, key_d;
  logic           in_ready_q, in_ready_d;
  logic           perm_start_q, perm_start_d;
  logic [319:0]   perm_state_q, perm_state_d;
  logic           st_valid_q, st_valid_d;
  logic [319:0]   st_out_q, st_out_d;
  logic           accept;

  // in_ready_q is high exactly while in LOAD, so it doubles as the state qualifier
  assign accept = in_valid & in_ready_q;

  // Next-state and datapath update; outputs are derived from the next state so they register cleanly
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    kn_d         = kn_q;
    key_d        = key_q;
    perm_state_d = perm_state_q;
    st_out_d     = st_out_q;
    case (state_q)
      IDLE: state_d = LOAD;
      LOAD: begin
        if (accept) begin
          // Shift register: after eight words, word 0 (K[127:96]) sits at the top
          kn_d  = {kn_q[223:0], in_data};
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd3) key_d = {kn_q[95:0], in_data};
          if (cnt_q == 3'd7) begin
            state_d      = START;
            cnt_d        = 3'd0;
            perm_state_d = {IV, kn_q[223:0], in_data};
          end
        end
      end
      START: state_d = WAIT;
      WAIT: begin
        if (perm_done) begin
          st_out_d = perm_out ^ {192'b0, key_q};
          state_d  = XOR;
        end
      end
      XOR:  state_d = HOLD;
      HOLD: if (st_ready) state_d = LOAD;
      default: state_d = IDLE;
    endcase
    in_ready_d   = (state_d == LOAD);
    perm_start_d = (state_d == START);
    st_valid_d   = (state_d == HOLD);
  end

  // State and output registers, all cleared by the asynchronous reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= 3'd0;
      kn_q         <= '0;
      key_q        <= '0;
      in_ready_q   <= 1'b0;
      perm_start_q <= 1'b0;
      perm_state_q <= '0;
      st_valid_q   <= 1'b0;
      st_out_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      kn_q         <= kn_d;
      key_q        <= key_d;
      in_ready_q   <= in_ready_d;
      perm_start_q <= perm_start_d;
      perm_state_q <= perm_state_d;
      st_valid_q   <= st_valid_d;
      st_out_q     <= st_out_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign perm_start = perm_start_q;
  assign perm_state = perm_state_q;
  assign st_valid   = st_valid_q;
  assign st_out     = st_out_q;
  assign key_out    = key_q;

endmodule

// File: tb/tb_ascon_init_loader.sv
// Scoreboard bench for ascon_init_loader with a fixed-latency permutation stub.
module tb_ascon_init_loader;

  localparam logic [63:0] IV = 64'h80400C0600000000;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic [31:0]  in_data = '0;
  logic         st_ready = 1'b1;
  logic         perm_done = 1'b0;
  logic [319:0] perm_out = '0;
  logic         in_ready, perm_start, st_valid;
  logic [319:0] perm_state, st_out;
  logic [127:0] key_out;

  int checks = 0;
  int failures = 0;

  logic [319:0] ps_q[$];
  logic [319:0] st_q[$];
  logic [319:0] stub_q[$];
  logic [127:0] key_q[$];

  int   stale_req = 0;
  int   stale_ack = 0;
  logic stale_flag = 1'b0;

  ascon_init_loader dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .perm_start(perm_start), .perm_state(perm_state), .perm_done(perm_done), .perm_out(perm_out),
    .st_valid(st_valid), .st_ready(st_ready), .st_out(st_out), .key_out(key_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b required %b", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm, input int act, input int exp);
    checks++;
    failures++;
    $display("FAIL %s: got %0d required %0d", nm, act, exp);
  endtask

  // Permutation stub: done 12 cycles after start; also injects stale done pulses on request
  logic [319:0] stub_v;
  initial begin
    forever begin
      @(negedge clk);
      if (perm_start) begin
        stub_v = (stub_q.size() != 0) ? stub_q.pop_front() : '0;
        repeat (12) @(posedge clk);
        #1 perm_done = 1'b1; perm_out = stub_v;
        @(posedge clk);
        #1 perm_done = 1'b0; perm_out = '0;
      end else if (stale_req != stale_ack) begin
        stale_ack = stale_req;
        @(posedge clk);
        #1 perm_done = 1'b1; perm_out = '1; stale_flag = 1'b1;
        @(posedge clk);
        #1 perm_done = 1'b0; perm_out = '0; stale_flag = 1'b0;
      end
    end
  end

  // Monitor / scoreboard
  int           acc_cnt = 0;
  int           d_cnt = -1;
  logic         pending_start = 1'b0;
  logic         busy = 1'b0;
  logic         hs_prev = 1'b0;
  logic         prev_sv = 1'b0;
  logic [319:0] prev_out = '0;
  logic [127:0] prev_key = '0;
  logic [319:0] last_ps = '0;
  logic [319:0] e;
  logic [127:0] ek;

  always @(negedge clk) begin
    if (!reset) begin
      chk1("rst_in_ready", in_ready, 1'b0);
      chk1("rst_perm_start", perm_start, 1'b0);
      chk1("rst_st_valid", st_valid, 1'b0);
      chk("rst_perm_state", perm_state, '0);
      chk("rst_st_out", st_out, '0);
      chk("rst_key_out", {192'b0, key_out}, '0);
      acc_cnt = 0; pending_start = 1'b0; d_cnt = -1; busy = 1'b0; hs_prev = 1'b0; prev_sv = 1'b0;
    end else begin
      if (hs_prev) begin
        chk1("st_valid_drop", st_valid, 1'b0);
        chk1("in_ready_rise", in_ready, 1'b1);
      end
      if (st_valid && prev_sv && !hs_prev) begin
        chk("hold_st_out", st_out, prev_out);
        chk("hold_key_out", {192'b0, key_out}, {192'b0, prev_key});
        chk1("hold_in_ready", in_ready, 1'b0);
      end
      if (pending_start) begin
        chk1("start_latency", perm_start, 1'b1);
        pending_start = 1'b0;
      end else if (perm_start) begin
        fail("spurious_start", 1, 0);
      end
      if (perm_start) begin
        chk1("start_while_busy", busy, 1'b0);
        busy = 1'b1;
        if (ps_q.size() == 0) fail("perm_state_unexpected", 1, 0);
        else begin
          e = ps_q.pop_front();
          last_ps = e;
          chk("perm_state", perm_state, e);
        end
      end
      if (d_cnt >= 0) d_cnt++;
      if (d_cnt == 1) chk1("xor_cycle_st_valid", st_valid, 1'b0);
      if (d_cnt == 2) begin
        chk1("st_valid_latency", st_valid, 1'b1);
        d_cnt = -1;
      end
      if (perm_done && !stale_flag) begin
        d_cnt = 0;
        chk("perm_state_hold", perm_state, last_ps);
      end
      if (in_valid && in_ready) begin
        acc_cnt++;
        if (acc_cnt == 8) begin
          acc_cnt = 0;
          pending_start = 1'b1;
        end
      end
      hs_prev = st_valid && st_ready;
      if (hs_prev) begin
        if (st_q.size() == 0) fail("unexpected_state", 1, 0);
        else begin
          e  = st_q.pop_front();
          ek = key_q.pop_front();
          chk("st_out", st_out, e);
          chk("key_out", {192'b0, key_out}, {192'b0, ek});
          busy = 1'b0;
        end
      end
      prev_sv = st_valid; prev_out = st_out; prev_key = key_out;
    end
  end

  // Stimulus
  task automatic load(input logic [127:0] k, input logic [127:0] n, input logic [319:0] pv,
                      input bit gaps, input int nwords);
    logic [255:0] kn;
    int i;
    int guard;
    logic v;
    logic acc;
    kn = {k, n}; i = 0; guard = 0; v = 1'b1;
    if (nwords == 8) begin
      ps_q.push_back({IV, k, n});
      stub_q.push_back(pv);
      st_q.push_back(pv ^ {192'b0, k});
      key_q.push_back(k);
    end
    while (i < nwords && guard < 2000) begin
      in_data  = kn[255 - 32*i -: 32];
      in_valid = v;
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) i++;
      if (gaps) v = ~v;
      guard++;
    end
    in_valid = 1'b0;
    if (i < nwords) fail("load_timeout", i, nwords);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((st_q.size() != 0 || st_valid) && g < 1000) begin
      @(posedge clk);
      g++;
    end
    #1;
    if (g >= 1000) fail("drain_timeout", g, 1000);
  endtask

  task automatic wait_valid();
    int g;
    g = 0;
    while (!st_valid && g < 500) begin
      @(negedge clk);
      g++;
    end
    if (g >= 500) fail("st_valid_timeout", g, 500);
  endtask

  task automatic wait_ready();
    int g;
    g = 0;
    while (!in_ready && g < 500) begin
      @(negedge clk);
      g++;
    end
    if (g >= 500) fail("in_ready_timeout", g, 500);
    @(posedge clk);
    #1;
  endtask

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2 = 128'hdeadbeef_01234567_89abcdef_cafef00d;
  localparam logic [127:0] N2 = 128'h11111111_22222222_33333333_44444444;
  localparam logic [127:0] K3 = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
  localparam logic [127:0] N3 = 128'ha5a5a5a5_5a5a5a5a_c3c3c3c3_3c3c3c3c;
  localparam logic [127:0] K4 = 128'hffffffff_eeeeeeee_dddddddd_cccccccc;
  localparam logic [127:0] K5 = 128'h13579bdf_2468ace0_fedcba98_76543210;
  localparam logic [127:0] N5 = 128'h01010101_02020202_03030303_04040404;
  localparam logic [127:0] K6 = 128'h00000000_00000000_00000000_00000001;
  localparam logic [127:0] K7 = 128'h80000000_00000000_00000000_00000000;

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk); chk1("idle_in_ready", in_ready, 1'b0);
    @(negedge clk); chk1("load_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // Reference key/nonce, all-ones permutation result
    load(K1, K1, '1, 1'b0, 8);
    drain();

    // Gapped input valid
    load(K2, N2, {160'h0123456789abcdef0123456789abcdef01234567, 160'h5}, 1'b1, 8);
    drain();

    // Downstream backpressure for 20 cycles
    st_ready = 1'b0;
    load(K3, N3, {5{64'h0f0f0f0f_f0f0f0f0}}, 1'b0, 8);
    wait_valid();
    repeat (20) @(posedge clk);
    #1 st_ready = 1'b1;
    drain();

    // Abort after five words, stale perm_done during LOAD, then reload
    load(K4, K4, '0, 1'b0, 5);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    wait_ready();
    stale_req++;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk1("stale_done_ignored", in_ready, 1'b1);
    @(posedge clk); #1;
    load(K5, N5, {64'h1, 64'h2, 64'h3, 64'h4, 64'h5}, 1'b0, 8);
    drain();

    // Back-to-back initializations with different keys
    load(K6, N2, {320{1'b1}} >> 7, 1'b0, 8);
    load(K7, N3, {10{32'h69696969}}, 1'b0, 8);
    drain();

    chk("leftover_expectations", 320'(st_q.size() + ps_q.size()), 320'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
